// File: rtl/vga_sync_gen.sv
// VGA timing generator: beam counters, sync/blank decodes, line/frame strobes,
// a frame counter and a tick-gated delay line for aligning with a pipelined colour path.
module vga_sync_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt,
    output logic       hsync_d,
    output logic       vsync_d,
    output logic       display_on_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit window bounds so an end value of 1024 still compares correctly
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    logic [9:0] hpos_reg, hpos_next;
    logic [9:0] vpos_reg, vpos_next;
    logic [7:0] frame_cnt_reg, frame_cnt_next;

    always_comb begin
        hpos_next      = hpos_reg;
        vpos_next      = vpos_reg;
        frame_cnt_next = frame_cnt_reg;
        if (tick) begin
            if (hpos_reg == H_LAST) begin
                hpos_next = '0;
                if (vpos_reg == V_LAST) begin
                    vpos_next      = '0;
                    frame_cnt_next = frame_cnt_reg + 8'd1;
                end else begin
                    vpos_next = vpos_reg + 10'd1;
                end
            end else begin
                hpos_next = hpos_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_reg      <= '0;
            vpos_reg      <= '0;
            frame_cnt_reg <= '0;
        end else begin
            hpos_reg      <= hpos_next;
            vpos_reg      <= vpos_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    logic [10:0] hpos_ext, vpos_ext;
    logic        h_vis, v_vis, hs_win, vs_win;

    assign hpos_ext = {1'b0, hpos_reg};
    assign vpos_ext = {1'b0, vpos_reg};
    assign h_vis    = hpos_ext < H_VIS;
    assign v_vis    = vpos_ext < V_VIS;
    assign hs_win   = (hpos_ext >= HS_START) && (hpos_ext < HS_END);
    assign vs_win   = (vpos_ext >= VS_START) && (vpos_ext < VS_END);

    // While reset is asserted the decodes present the idle/blank state
    assign display_on  = !reset && h_vis && v_vis;
    assign hsync       = (!reset && hs_win) ? SYNC_ON : SYNC_OFF;
    assign vsync       = (!reset && vs_win) ? SYNC_ON : SYNC_OFF;
    assign line_start  = !reset && tick && (hpos_reg == 10'd0);
    assign frame_start = !reset && tick && (hpos_reg == 10'd0) && (vpos_reg == 10'd0);

    assign hpos      = hpos_reg;
    assign vpos      = vpos_reg;
    assign frame_cnt = frame_cnt_reg;

    // Delay line bit order: {hsync, vsync, display_on}
    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hsync_d      = hsync;
            assign vsync_d      = vsync;
            assign display_on_d = display_on;
        end else begin : g_delay
            logic [2:0] pipe_reg [PIPE_DELAY];
            for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
                logic [2:0] stage_in;
                if (gi == 0) begin : g_head
                    assign stage_in = {hsync, vsync, display_on};
                end else begin : g_body
                    assign stage_in = pipe_reg[gi-1];
                end
                always_ff @(posedge clk) begin
                    if (reset) begin
                        pipe_reg[gi] <= {SYNC_OFF, SYNC_OFF, 1'b0};
                    end else if (tick) begin
                        pipe_reg[gi] <= stage_in;
                    end
                end
            end
            assign hsync_d      = pipe_reg[PIPE_DELAY-1][2];
            assign vsync_d      = pipe_reg[PIPE_DELAY-1][1];
            assign display_on_d = pipe_reg[PIPE_DELAY-1][0];
        end
    endgenerate

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parameterised VGA timing generator that sits directly upstream of the pixel-shading logic. It produces the horizontal and vertical beam counters, the active-video flag and the sync pulses that the shading stage decodes into colour. It also provides line/frame strobes, a frame counter for animation, and a configurable delay line so that sync and active-video can be aligned with a pipelined colour path.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- PIPE_DELAY, 0, cycles of delay on the `_d` outputs (0..7)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  pixel advance enable; counters advance only when tick=1
- hpos  out  10  horizontal counter, 0..H_TOTAL-1
- vpos  out  10  vertical counter, 0..V_TOTAL-1
- display_on  out  1  1 when hpos<H_ACTIVE and vpos<V_ACTIVE
- hsync  out  1  horizontal sync at SYNC_POL level during the sync window
- vsync  out  1  vertical sync at SYNC_POL level during the sync window
- line_start  out  1  1 when hpos==0 and tick==1
- frame_start  out  1  1 when hpos==0, vpos==0 and tick==1
- frame_cnt  out  8  completed-frame counter, wraps 255->0
- hsync_d, vsync_d, display_on_d  out  1 each  same signals delayed by PIPE_DELAY ticks

## Operation
- H_TOTAL = sum of H parameters (800); V_TOTAL = sum of V parameters (525).
- The only registers are hpos, vpos, frame_cnt and the delay line. display_on, hsync, vsync, line_start and frame_start are combinational decodes of the current registers and tick.
- On tick=1:
  - hpos increments.
  - At hpos==H_TOTAL-1, hpos wraps to 0 and vpos increments.
  - At vpos==V_TOTAL-1 with hpos==H_TOTAL-1, vpos wraps to 0 and frame_cnt increments (mod 256).
- On tick=0, all registers hold.
- Sync windows:
  - hsync is active for H_ACTIVE+H_FRONT <= hpos < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vsync is active for V_ACTIVE+V_FRONT <= vpos < V_ACTIVE+V_FRONT+V_SYNC (490..491).
  - Outside these windows, both are at ~SYNC_POL.
- Delay line:
  - Depth PIPE_DELAY shift register carrying {hsync, vsync, display_on}.
  - Shifts only on tick=1.
  - PIPE_DELAY=0: the `_d` outputs are combinational copies of the undelayed signals.
- Reset (sampled on a clk edge, overrides tick):
  - hpos=0, vpos=0, frame_cnt=0.
  - Every delay stage loads {~SYNC_POL, ~SYNC_POL, 0}.
  - While reset=1, display_on, line_start and frame_start are forced to 0, and hsync/vsync are forced to ~SYNC_POL.
- Counter arithmetic is unsigned and 10 bits wide. Parameter sums must be <=1024; this is not checked in RTL.

## Timing
- Zero latency from hpos/vpos to display_on, hsync, vsync and the strobes.
- `_d` outputs lag their source by exactly PIPE_DELAY ticks. Stalled (tick=0) cycles do not count.
- First cycle after reset deasserts: hpos=0, vpos=0, display_on=1, hsync=vsync=~SYNC_POL. frame_start=1 if tick=1.
- Full frame = 420000 ticks at default parameters.
- frame_cnt changes on the clk edge that moves (799,524) to (0,0), i.e. in the same cycle that frame_start first asserts for the new frame.
- Reset mid-line or mid-frame: the next cycle is identical to post-reset. The delay line is flushed, so `_d` outputs are inactive for PIPE_DELAY ticks.
- tick=0 during a wrap cycle: no wrap, no frame_cnt increment, and no strobe until tick returns.

## Test plan
- Reset with tick=1:
  - During reset: display_on=0, hsync=vsync=1.
  - First cycle after release: hpos=0, vpos=0, display_on=1, frame_start=1, frame_cnt=0.
- Free-run one line:
  - display_on falls at hpos=640.
  - hsync=0 exactly for hpos 656..751 (96 cycles).
  - At hpos 799 -> 0, vpos goes 0 -> 1 and line_start=1.
- Free-run a full frame:
  - vsync=0 exactly for vpos 490..491 (1600 ticks).
  - display_on=0 for all of vpos 480..524.
  - After 420000 ticks, frame_cnt=1 and frame_start pulses once.
- Tick gating:
  - tick toggling 1,0,1,0 advances hpos by 1 every two clocks.
  - Holding tick=0 at (799,524) freezes the state with frame_cnt unchanged and frame_start=0.
  - Releasing tick wraps to (0,0) and frame_cnt increments.
- PIPE_DELAY=3:
  - display_on_d falls 3 ticks after display_on, i.e. when hpos=643.
  - hsync_d is low for hpos 659..754.
  - With tick stalls inserted, the delay measured in ticks remains 3.
- Reset mid-frame at (300,200), held for 2 cycles, with PIPE_DELAY=2:
  - Outputs return to (0,0) and frame_cnt=0.
  - display_on_d stays 0 for 2 ticks after release, then follows display_on.
- frame_cnt wrap: after 256 frames (or with frame_cnt forced to 255), the next wrap gives frame_cnt=0.
